bram_stream_reader: RTL

- Downstream consumer of the dual-port BRAM that the write stage fills through port A.
- Owns BRAM port B. On a start pulse it reads word_cnt consecutive 32-bit words from base_addr, stepping the byte address by 4.
- Absorbs the BRAM read latency in a small credit-controlled FIFO and presents the words as a valid/ready stream with a last flag and a running sum.
- Never writes the BRAM.

---
 rtl/bram_stream_reader.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/bram_stream_reader.sv
// bram_stream_reader
// Reads a block of consecutive 32-bit words from BRAM port B and presents
// them as a valid/ready stream with a last flag and a running sum.
// The reader only reads; the write stage owns port A.
//
// Ports:
//   clk, reset          system clock; asynchronous active-low reset
//   start               one-cycle job request, sampled only when idle
//   base_addr, word_cnt job byte address and word count, sampled with start
//   busy, done          job in progress / one-cycle completion pulse
//   addrb, clkb, rstb, enb, web, dinb, doutb   BRAM port B
//   m_data, m_valid, m_ready, m_last           output stream
//   sum                 mod-2^32 sum of words transferred in the current job
module bram_stream_reader #(
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_STEP  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic [15:0] word_cnt,
  output logic        busy,
  output logic        done,
  output logic [31:0] addrb,
  output logic        clkb,
  output logic        rstb,
  output logic        enb,
  output logic [3:0]  web,
  output logic [31:0] dinb,
  input  logic [31:0] doutb,
  output logic [31:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        m_last,
  output logic [31:0] sum
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;

  state_t state;

  logic [15:0]       cnt_reg;
  logic [15:0]       issued;
  logic [15:0]       xfer;
  logic [CW-1:0]     occ;
  logic [CW-1:0]     occ_next;
  logic              can_issue;
  logic [RD_LAT-1:0] vpipe;
  logic              wr;
  logic              pop;

  logic [31:0]       fifo_mem [0:FIFO_DEPTH-1];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     fifo_count;

  // Port B is read-only.
  assign clkb = clk;
  assign rstb = 1'b0;
  assign web  = 4'b0000;
  assign dinb = 32'd0;

  // Stream side: head of the FIFO; the head's word index equals the number
  // of words already transferred, which marks the last word.
  assign m_valid = (fifo_count != '0);
  assign m_data  = fifo_mem[rd_ptr];
  assign pop     = m_valid & m_ready;
  assign m_last  = m_valid && (xfer == cnt_reg - 16'd1);

  // A read that comes out of the end of the latency pipe lands in the FIFO.
  assign wr = vpipe[RD_LAT-1];

  // occ = FIFO entries + reads in flight. enb is registered, so the decision
  // to issue in the next cycle uses next cycle's occupancy.
  assign occ_next  = occ + CW'(enb) - CW'(pop);
  assign can_issue = (occ_next < CW'(FIFO_DEPTH));

  generate
    if (RD_LAT == 1) begin : g_lat1
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) vpipe <= '0;
        else        vpipe <= enb;
      end
    end else begin : g_latn
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) vpipe <= '0;
        else        vpipe <= {vpipe[RD_LAT-2:0], enb};
      end
    end
  endgenerate

  // FIFO storage; contents need no reset since pointers are cleared.
  always_ff @(posedge clk) begin
    if (wr) fifo_mem[wr_ptr] <= doutb;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + CW'(wr) - CW'(pop);
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      enb     <= 1'b0;
      addrb   <= 32'd0;
      sum     <= 32'd0;
      cnt_reg <= 16'd0;
      issued  <= 16'd0;
      xfer    <= 16'd0;
      occ     <= '0;
    end else begin
      done <= 1'b0;
      enb  <= 1'b0;
      occ  <= occ_next;

      if (pop) begin
        sum  <= sum + m_data;
        xfer <= xfer + 16'd1;
      end

      case (state)
        IDLE: begin
          if (start) begin
            sum  <= 32'd0;
            xfer <= 16'd0;
            if (word_cnt != 16'd0) begin
              // The FIFO is empty between jobs, so the first read can
              // always issue in the cycle right after start.
              cnt_reg <= word_cnt;
              enb     <= 1'b1;
              addrb   <= base_addr;
              issued  <= 16'd1;
              busy    <= 1'b1;
              state   <= ISSUE;
            end else begin
              cnt_reg <= 16'd0;
              issued  <= 16'd0;
              done    <= 1'b1;
              state   <= FIN;
            end
          end
        end

        ISSUE: begin
          // issued already counts a read whose enb is high this cycle.
          if (issued == cnt_reg) begin
            state <= DRAIN;
          end else if (can_issue) begin
            enb    <= 1'b1;
            addrb  <= addrb + 32'(ADDR_STEP);
            issued <= issued + 16'd1;
          end
        end

        DRAIN: begin
          // Finish as the last word leaves so done lands on the next cycle.
          if (pop && (xfer == cnt_reg - 16'd1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end
        end

        FIN: begin
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

  // The credit scheme must make a write into a full FIFO impossible.
  assert property (@(posedge clk) disable iff (!reset)
                   (wr && !pop) |-> (fifo_count != CW'(FIFO_DEPTH)));

endmodule
